// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type and default frame geometry.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw line through two stages.
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // Synchronizer flops, reset to line-idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing with a one-byte holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud,
    input  logic                 data_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] MidTick  = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] LastTick = CntW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] LastBit  = IdxW'(DATA_BITS - 1);

    logic                 line;
    uart_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 byte_done;
    logic                 accept;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (data_in),
        .q   (line)
    );

    // Frame FSM. In StStop the bit index still reads LastBit while the stop bit is being
    // timed; it is cleared on a framing error to mark "wait for the line to return high".
    // This relies on DATA_BITS >= 2.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        byte_done   = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (baud && !line) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (baud) begin
                    if (cnt_q == MidTick) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = line ? StIdle : StData;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (baud) begin
                    if (cnt_q == LastTick) begin
                        cnt_d   = '0;
                        shift_d = {line, shift_q[DATA_BITS-1:1]};
                        if (idx_q == LastBit) begin
                            state_d = StStop;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (idx_q != LastBit) begin
                    if (line) begin
                        state_d = StIdle;
                    end
                end else if (baud) begin
                    if (cnt_q == LastTick) begin
                        if (line) begin
                            byte_done = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            idx_d       = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding register: a completed byte loads if the slot is empty or being freed this clk.
    always_comb begin
        accept    = valid_q && rx_ready;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (accept) begin
            valid_d = 1'b0;
        end
        if (byte_done) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out     = data_q;
    assign rx_valid     = valid_q;
    assign rx_busy      = (state_q != StIdle);
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a
// byte-level model of the holding register.
module tb_uart_rx;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int BAUD_DIV = 4;

    logic          clk;
    logic          rst;
    logic          baud;
    logic          data_in;
    logic          rx_ready;
    logic [DB-1:0] data_out;
    logic          rx_valid;
    logic          rx_busy;
    logic          rx_frame_err;
    logic          rx_overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int done_clk = 0;

    // Reference model of what the consumer should see.
    logic          exp_valid;
    logic [DB-1:0] exp_data;

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud         (baud),
        .data_in      (data_in),
        .rx_ready     (rx_ready),
        .data_out     (data_out),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running baud strobe, one clk in every BAUD_DIV.
    initial begin
        int bcnt;
        bcnt = 0;
        baud = 1'b0;
        forever begin
            @(negedge clk);
            bcnt = (bcnt + 1) % BAUD_DIV;
            baud = (bcnt == 0);
        end
    end

    // Count single-clk pulses so each event can be checked as exactly one pulse.
    always @(posedge clk) begin
        if (rx_frame_err) fe_cnt <= fe_cnt + 1;
        if (rx_overrun)   ov_cnt <= ov_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobes(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (baud) k++;
        end
        @(negedge clk);
    endtask

    // Drive one frame. ready_at: clk offset at which rx_ready is high for one clk (0 = never).
    // rst_at: strobe count at which rst is pulsed and the frame abandoned (0 = never).
    task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit,
                              input int ready_at, input int rst_at);
        int strobes;
        int clk_n;
        int bitn;
        int found;
        bit busy_seen;
        bit aborted;
        strobes   = 0;
        clk_n     = 0;
        found     = 0;
        busy_seen = 1'b0;
        aborted   = 1'b0;
        do @(posedge clk); while (baud !== 1'b1);
        @(negedge clk);
        data_in = 1'b0;
        while (strobes < (DB + 2) * OS && !aborted) begin
            @(posedge clk);
            clk_n++;
            if (baud) strobes++;
            @(negedge clk);
            if (rx_busy) busy_seen = 1'b1;
            else if (busy_seen && found == 0) found = clk_n;
            rx_ready = (clk_n == ready_at - 1);
            if (rst) begin
                rst     = 1'b0;
                aborted = 1'b1;
                data_in = 1'b1;
            end else if (rst_at > 0 && strobes == rst_at) begin
                rst = 1'b1;
            end
            if (!aborted) begin
                bitn = strobes / OS;
                if (bitn == 0)       data_in = 1'b0;
                else if (bitn <= DB) data_in = b[bitn-1];
                else                 data_in = stop_bit;
            end
        end
        rx_ready = 1'b0;
        if (!aborted && found != 0) done_clk = found;
    endtask

    // mode 0: rx_ready idle; 1: one-clk rx_ready pulse before the frame;
    // 2: rx_ready high in the clk the frame completes.
    task automatic frame(input string tag, input logic [DB-1:0] b, input logic stop_bit,
                         input int mode);
        int  fe0;
        int  ov0;
        bit  acc;
        bit  exp_ov;
        bit  exp_fe;
        exp_ov = 1'b0;
        exp_fe = 1'b0;
        if (mode == 1) begin
            @(negedge clk);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            if (exp_valid) exp_valid = 1'b0;
        end
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(b, stop_bit, (mode == 2) ? done_clk : 0, 0);
        data_in = 1'b1;
        acc = (mode == 2) && exp_valid;
        if (stop_bit) begin
            if (exp_valid && !acc) begin
                exp_ov = 1'b1;
            end else begin
                exp_data  = b;
                exp_valid = 1'b1;
            end
        end else begin
            exp_fe = 1'b1;
            if (acc) exp_valid = 1'b0;
        end
        wait_strobes(2);
        chk({tag, "_valid"}, {31'd0, rx_valid}, {31'd0, exp_valid});
        chk({tag, "_data"}, {24'd0, data_out}, {24'd0, exp_data});
        chk({tag, "_ferr"}, fe_cnt - fe0, {31'd0, exp_fe});
        chk({tag, "_ovr"}, ov_cnt - ov0, {31'd0, exp_ov});
        chk({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
    endtask

    initial begin
        int fe0;
        int ov0;
        logic [DB-1:0] rb;
        rst       = 1'b1;
        data_in   = 1'b1;
        rx_ready  = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
        rst = 1'b0;
        wait_strobes(4);

        // Basic reception, byte held with rx_ready low.
        frame("f55", 8'h55, 1'b1, 0);

        // Free the slot, receive 0xA3, then accept it.
        frame("fa3", 8'hA3, 1'b1, 1);
        rx_ready = 1'b1;
        chk("acc_before", {31'd0, rx_valid}, 32'd1);
        @(negedge clk);
        rx_ready  = 1'b0;
        exp_valid = 1'b0;
        chk("acc_clear", {31'd0, rx_valid}, 32'd0);
        chk("acc_data", {24'd0, data_out}, 32'hA3);

        // rx_ready with nothing held does nothing.
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        chk("idle_ready_valid", {31'd0, rx_valid}, 32'd0);
        chk("idle_ready_data", {24'd0, data_out}, 32'hA3);

        // Start-bit glitch: low for 4 strobes only.
        fe0 = fe_cnt;
        do @(posedge clk); while (baud !== 1'b1);
        @(negedge clk);
        data_in = 1'b0;
        wait_strobes(4);
        chk("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
        data_in = 1'b1;
        wait_strobes(8);
        chk("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
        chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
        chk("glitch_ferr", fe_cnt - fe0, 32'd0);

        // Framing error: stop bit low, line held low afterwards.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 0, 0);
        wait_strobes(4);
        chk("ferr_pulse", fe_cnt - fe0, 32'd1);
        chk("ferr_hold_busy", {31'd0, rx_busy}, 32'd1);
        chk("ferr_valid", {31'd0, rx_valid}, 32'd0);
        data_in = 1'b1;
        wait_strobes(2);
        chk("ferr_release_busy", {31'd0, rx_busy}, 32'd0);
        chk("ferr_single", fe_cnt - fe0, 32'd1);

        // Overrun, then a completion coinciding with acceptance.
        frame("f11", 8'h11, 1'b1, 0);
        frame("f22_ovr", 8'h22, 1'b1, 0);
        frame("f22_acc", 8'h22, 1'b1, 2);

        // Reset during data bit 3 abandons the frame.
        ov0 = ov_cnt;
        send_frame(8'h5A, 1'b1, 0, 4 * OS + OS / 2);
        chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, data_out}, 32'd0);
        exp_valid = 1'b0;
        exp_data  = '0;
        data_in   = 1'b1;
        wait_strobes(2 * OS);
        chk("mid_rst_quiet", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_ovr", ov_cnt - ov0, 32'd0);
        frame("f81", 8'h81, 1'b1, 0);

        // Random frames, ready modes and occasional bad stop bits.
        for (int i = 0; i < 8; i++) begin
            rb = DB'($urandom);
            frame("rnd", rb, ($urandom_range(0, 4) != 0), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
